// File: rtl/mem_tick_sequencer_if.sv
// Bundle between the tick sequencer and its environment: slow-clock input,
// run control, the single-port memory bus and the display-stage outputs.
interface mem_tick_sequencer_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          slow_clk;
    logic          start;
    logic          mode;
    logic          pause;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          busy;
    logic          done;

    // Sequencer side: drives the memory bus and the display outputs.
    modport master (
        input  slow_clk, start, mode, pause, mem_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output disp_addr, disp_data, disp_valid, busy, done
    );

    // Environment side: slow clock, run control and memory read data.
    modport slave (
        output slow_clk, start, mode, pause, mem_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  disp_addr, disp_data, disp_valid, busy, done
    );
endinterface

// File: rtl/mem_tick_sequencer.sv
// Walks a single-port memory at the rate of the divided slow clock: optional
// pattern fill, then an in-order read-back whose results go to the display stage.
module mem_tick_sequencer #(
    parameter int            AW   = 4,
    parameter int            DW   = 8,
    parameter logic [DW-1:0] SEED = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_tick_sequencer_if.master  io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SCAN_REQ,
        S_SCAN_CAP,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [AW-1:0] r_addr;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [AW-1:0] r_disp_addr;
    logic [DW-1:0] r_disp_data;
    logic          r_disp_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_tick;
    logic          w_etick;
    logic          w_last;
    logic [DW-1:0] w_fill_data;

    // slow_clk is asynchronous data: two flops synchronise, the third finds its rising edge.
    assign w_tick      = r_s2 & ~r_s3;
    assign w_etick     = w_tick & ~io_bus.pause;
    assign w_last      = (r_addr == {AW{1'b1}});
    assign w_fill_data = DW'(r_addr) ^ SEED;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_addr       <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_disp_addr  <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // Edge detector keeps running through pause so a release cannot fake a tick.
            r_s1         <= io_bus.slow_clk;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_disp_valid <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (io_bus.start) begin
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= io_bus.mode ? S_FILL : S_SCAN_REQ;
                    end
                end

                S_FILL: begin
                    if (w_etick) begin
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_fill_data;
                        r_addr      <= r_addr + AW'(1);
                        if (w_last) begin
                            r_state <= S_SCAN_REQ;
                        end
                    end
                end

                S_SCAN_REQ: begin
                    if (w_etick) begin
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                        r_state    <= S_SCAN_CAP;
                    end
                end

                // Read data is due at the end of the access cycle; capture it unconditionally.
                S_SCAN_CAP: begin
                    r_disp_data  <= io_bus.mem_rdata;
                    r_disp_addr  <= r_addr;
                    r_disp_valid <= 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + AW'(1);
                        r_state <= S_SCAN_REQ;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.mem_en     = r_mem_en;
    assign io_bus.mem_we     = r_mem_we;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_wdata  = r_mem_wdata;
    assign io_bus.disp_addr  = r_disp_addr;
    assign io_bus.disp_data  = r_disp_data;
    assign io_bus.disp_valid = r_disp_valid;
    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
endmodule

// File: tb/tb_mem_tick_sequencer.sv
// Bench for mem_tick_sequencer: directed and randomised runs compared against a
// transaction-level model built from the slow-clock edges, pause window and memory image.
module tb_mem_tick_sequencer;
    localparam int            AW    = 4;
    localparam int            DW    = 8;
    localparam logic [DW-1:0] SEED  = 8'hA5;
    localparam int            DEPTH = 1 << AW;
    localparam int            MAXC  = 20000;

    typedef struct packed {
        int unsigned   cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct packed {
        int unsigned   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } disp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            slow_per = 2;
    logic [DW-1:0] pre     [DEPTH];
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    acc_t          acc_q[$];
    disp_t         disp_q[$];
    int unsigned   rise_q[$];
    bit            pause_log [MAXC];

    mem_tick_sequencer_if #(.AW(AW), .DW(DW)) u_if ();

    mem_tick_sequencer #(.AW(AW), .DW(DW), .SEED(SEED)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slow clock: period slow_per clk, high for the first half, changes 1 ns after posedge.
    initial begin
        int cnt;
        cnt = 0;
        u_if.slow_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt = (cnt + 1 >= slow_per) ? 0 : cnt + 1;
            u_if.slow_clk = (cnt < slow_per / 2);
        end
    end

    // Memory whose read data settles within the access cycle.
    initial begin
        u_if.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (load_req === 1'b1) begin
                for (int i = 0; i < DEPTH; i++) ram[i] = pre[i];
            end else if (u_if.mem_en === 1'b1) begin
                if (u_if.mem_we) ram[u_if.mem_addr] = u_if.mem_wdata;
                else             u_if.mem_rdata = ram[u_if.mem_addr];
            end
        end
    end

    // Event log: accesses, display pulses, slow_clk rises and the pause level per cycle.
    initial begin
        logic sc_prev;
        sc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc < MAXC) pause_log[cyc] = (u_if.pause === 1'b1);
            if (u_if.slow_clk && !sc_prev) rise_q.push_back(cyc);
            sc_prev = u_if.slow_clk;
            if (u_if.mem_en === 1'b1)
                acc_q.push_back(acc_t'{cyc, u_if.mem_we, u_if.mem_addr,
                                       (u_if.mem_we ? u_if.mem_wdata : {DW{1'b0}})});
            if (u_if.disp_valid === 1'b1)
                disp_q.push_back(disp_t'{cyc, u_if.disp_addr, u_if.disp_data});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = rnd ? DW'($urandom) : DW'(i * 3);
            pre[i]     = exp_mem[i];
        end
        @(posedge clk);
        #1 load_req = 1'b1;
        @(negedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic do_run(input bit mode, input int inject_at, input bit do_pause,
                          output int a0, output int d0);
        int unsigned s, c5, p_off, t;
        int          lim, nxt, total, last_rd, idx, n_in_pause;
        bit          pausing, pause_done, injected;
        acc_t        exp_acc[$];
        disp_t       exp_disp[$];
        a0 = acc_q.size();
        d0 = disp_q.size();
        pausing = 0; pause_done = 0; injected = 0; c5 = 0; p_off = 0;

        @(posedge clk);
        #1;
        s = cyc;
        u_if.mode  = mode;
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        u_if.mode  = ~mode;
        @(negedge clk);
        chk("launch_busy", 64'(u_if.busy), 64'd1);
        chk("launch_done", 64'(u_if.done), 64'd0);

        lim = 0;
        while (u_if.done !== 1'b1 && lim < 3000) begin
            @(posedge clk);
            #1;
            lim++;
            u_if.start = 1'b0;
            if (inject_at >= 0 && !injected && (disp_q.size() - d0) == inject_at) begin
                u_if.start = 1'b1;
                u_if.mode  = ~mode;
                injected   = 1;
            end
            if (do_pause && !pausing && !pause_done && acc_q.size() > a0 &&
                acc_q[$].we == 1'b0 && acc_q[$].addr == AW'(5)) begin
                pausing    = 1;
                c5         = acc_q[$].cyc;
                p_off      = cyc + 3 * slow_per;
                u_if.pause = 1'b1;
            end else if (pausing && cyc >= p_off) begin
                chk("pause_addr_hold", 64'(u_if.mem_addr), 64'd5);
                u_if.pause = 1'b0;
                pausing    = 0;
                pause_done = 1;
            end
        end
        chk("run_finished", 64'(lim < 3000), 64'd1);
        @(negedge clk);
        chk("done_level", 64'(u_if.done), 64'd1);
        chk("busy_after_done", 64'(u_if.busy), 64'd0);

        if (do_pause) begin
            chk("pause_applied", 64'(pause_done), 64'd1);
            n_in_pause = 0;
            for (int i = a0; i < acc_q.size(); i++)
                if (acc_q[i].cyc > c5 && acc_q[i].cyc <= p_off) n_in_pause++;
            chk("no_access_while_paused", 64'(n_in_pause), 64'd0);
        end

        // Reference: every unpaused slow_clk rise seen at cycle r issues an access at r+3,
        // the run consumes one such tick per access, and a read occupies its next cycle.
        total   = mode ? 2 * DEPTH : DEPTH;
        nxt     = 0;
        last_rd = -10;
        for (int i = 0; i < rise_q.size() && nxt < total; i++) begin
            t = rise_q[i] + 3;
            if (t < s + 2 || rise_q[i] + 2 >= MAXC) continue;
            if (pause_log[rise_q[i] + 2]) continue;
            if (int'(t) == last_rd + 1) continue;
            if (mode && nxt < DEPTH) begin
                exp_mem[nxt] = DW'(nxt) ^ SEED;
                exp_acc.push_back(acc_t'{t, 1'b1, AW'(nxt), DW'(nxt) ^ SEED});
            end else begin
                idx = mode ? nxt - DEPTH : nxt;
                exp_acc.push_back(acc_t'{t, 1'b0, AW'(idx), {DW{1'b0}}});
                exp_disp.push_back(disp_t'{t + 1, AW'(idx), exp_mem[idx]});
                last_rd = int'(t);
            end
            nxt++;
        end

        chk("access_count", 64'(acc_q.size() - a0), 64'(total));
        for (int i = 0; i < exp_acc.size() && a0 + i < acc_q.size(); i++)
            chk($sformatf("access[%0d]", i), 64'(acc_q[a0 + i]), 64'(exp_acc[i]));
        chk("disp_count", 64'(disp_q.size() - d0), 64'(DEPTH));
        for (int i = 0; i < exp_disp.size() && d0 + i < disp_q.size(); i++)
            chk($sformatf("disp[%0d]", i), 64'(disp_q[d0 + i]), 64'(exp_disp[i]));
    endtask

    initial begin
        int a0, d0, lim;
        bit m;
        rst        = 1'b1;
        load_req   = 1'b0;
        u_if.start = 1'b0;
        u_if.mode  = 1'b0;
        u_if.pause = 1'b0;
        slow_per   = 2;

        // Reset with slow_clk toggling every clk.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en",     64'(u_if.mem_en),     64'd0);
        chk("rst_mem_we",     64'(u_if.mem_we),     64'd0);
        chk("rst_mem_addr",   64'(u_if.mem_addr),   64'd0);
        chk("rst_mem_wdata",  64'(u_if.mem_wdata),  64'd0);
        chk("rst_disp_addr",  64'(u_if.disp_addr),  64'd0);
        chk("rst_disp_data",  64'(u_if.disp_data),  64'd0);
        chk("rst_disp_valid", 64'(u_if.disp_valid), 64'd0);
        chk("rst_busy",       64'(u_if.busy),       64'd0);
        chk("rst_done",       64'(u_if.done),       64'd0);
        rst      = 1'b0;
        slow_per = 4;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_no_access", 64'(acc_q.size()), 64'd0);
        chk("idle_busy",      64'(u_if.busy),    64'd0);
        chk("idle_done",      64'(u_if.done),    64'd0);

        // Fill then scan at slow period 4.
        do_run(1'b1, -1, 1'b0, a0, d0);
        if (acc_q.size() >= a0 + 16) begin
            chk("fill_first_wdata", 64'(acc_q[a0].data),      64'hA5);
            chk("fill_wdata_1",     64'(acc_q[a0 + 1].data),  64'hA4);
            chk("fill_wdata_15",    64'(acc_q[a0 + 15].data), 64'hAA);
        end
        if (disp_q.size() >= d0 + 16)
            chk("scan_last_data", 64'(disp_q[d0 + 15].data), 64'hAA);

        // Scan only over mem[i] = i*3, started from DONE.
        preload(1'b0);
        do_run(1'b0, -1, 1'b0, a0, d0);
        if (disp_q.size() >= d0 + 16) begin
            chk("scan3_last_data", 64'(disp_q[d0 + 15].data), 64'h2D);
            chk("scan3_spacing_0", 64'(disp_q[d0 + 1].cyc - disp_q[d0].cyc), 64'd4);
            chk("scan3_spacing_14", 64'(disp_q[d0 + 15].cyc - disp_q[d0 + 14].cyc), 64'd4);
        end

        // Pause for three tick periods after the read of addr 5.
        preload(1'b1);
        slow_per = $urandom_range(7, 4);
        do_run(1'b0, -1, 1'b1, a0, d0);

        // Reset one clk after the addr-7 write of a fill.
        slow_per = 4;
        a0 = acc_q.size();
        @(posedge clk);
        #1;
        u_if.mode  = 1'b1;
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        lim = 0;
        while (acc_q.size() < a0 + 8 && lim < 500) begin
            @(posedge clk);
            #1;
            lim++;
        end
        chk("abort_reached_w7", 64'(lim < 500), 64'd1);
        if (acc_q.size() >= a0 + 8)
            chk("abort_w7_addr", 64'(acc_q[a0 + 7].addr), 64'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy",     64'(u_if.busy),     64'd0);
        chk("abort_mem_en",   64'(u_if.mem_en),   64'd0);
        chk("abort_mem_addr", 64'(u_if.mem_addr), 64'd0);
        chk("abort_done",     64'(u_if.done),     64'd0);
        rst = 1'b0;
        repeat (3 * slow_per + 4) @(posedge clk);
        #1;
        chk("abort_no_more_access", 64'(acc_q.size() - a0), 64'd8);
        do_run(1'b1, -1, 1'b0, a0, d0);
        if (acc_q.size() > a0) begin
            chk("restart_addr0",  64'(acc_q[a0].addr), 64'd0);
            chk("restart_wdata0", 64'(acc_q[a0].data), 64'hA5);
        end

        // Start pulsed mid-scan must be ignored.
        preload(1'b1);
        do_run(1'b0, 6, 1'b0, a0, d0);
        do_run(1'b1, 20, 1'b0, a0, d0);

        // Randomised runs: mode, slow period, memory image and pause.
        for (int r = 0; r < 4; r++) begin
            slow_per = $urandom_range(7, 4);
            m = 1'($urandom_range(1, 0));
            if (!m) preload(1'b1);
            do_run(m, -1, 1'($urandom_range(1, 0)), a0, d0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_tick_sequencer.md
Name: mem_tick_sequencer

Overview:
- Consumes the slow clock produced by the frequency divider and walks a synchronous single-port memory at that rate.
- Optionally fills the memory with an address-derived pattern first, then reads every location back in order.
- Presents each address/data pair to the display stage.
- Runs entirely in the fast clk domain; the slow clock is treated as a data signal and converted to a one-cycle tick.

Parameters:
AW, 4, memory address width (depth = 2^AW)
DW, 8, memory data width (DW >= AW)
SEED, 8'hA5, fill-pattern XOR constant (DW bits)

Ports:
clk  in  1  system clock, the only clock
rst  in  1  synchronous, active-high reset
slow_clk  in  1  divided clock from the divider, sampled as data
start  in  1  level; sampled in IDLE/DONE to launch a run
mode  in  1  sampled with start: 1 = FILL then SCAN, 0 = SCAN only
pause  in  1  while 1, ticks are ignored (not queued)
mem_en  out  1  memory access strobe, one clk wide
mem_we  out  1  write enable, valid with mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid 1 clk after mem_en with mem_we=0
disp_addr  out  AW  address of last captured read
disp_data  out  DW  data of last captured read
disp_valid  out  1  one-clk pulse when disp_* update
busy  out  1  high in FILL/SCAN_REQ/SCAN_CAP
done  out  1  high in DONE

Behaviour:
- Tick generation: 3-flop chain s1<=slow_clk, s2<=s1, s3<=s2; tick = s2 & ~s3 (rising edge of slow_clk, 2-clk sync latency). The divider guarantees ticks are >= 2 clk apart, so no tick falls in SCAN_CAP back-to-back with its own request.
- Effective tick: etick = tick & ~pause.
- Reset (rst=1 at a clk edge): state=IDLE, s1..s3=0, addr=0. All outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, disp_addr, disp_data, disp_valid, busy, done). Reset mid-run aborts with no further memory access.
- mem_en/mem_we are registered pulses. mem_addr and mem_wdata are held between accesses.
- IDLE:
  - start=1 -> addr=0; go to FILL if mode=1, else SCAN_REQ.
- FILL:
  - On etick, issue a one-clk write: mem_en=1, mem_we=1, mem_addr=addr, mem_wdata = zero-extend(addr to DW) ^ SEED.
  - If addr = 2^AW-1: addr wraps to 0, go to SCAN_REQ. Otherwise addr+1.
- SCAN_REQ:
  - On etick, issue a one-clk read (mem_en=1, mem_we=0, mem_addr=addr), go to SCAN_CAP.
- SCAN_CAP (exactly one clk):
  - Capture mem_rdata into disp_data and addr into disp_addr; disp_valid=1 for this one clk.
  - If addr = 2^AW-1, go to DONE; otherwise addr+1 and go to SCAN_REQ.
- DONE:
  - done=1, held until start=1, which clears done and relaunches exactly as from IDLE (mode re-sampled).
- start while busy is ignored.
- pause:
  - Gates only the issuing of new accesses; a read already issued still completes its SCAN_CAP.
  - The tick flops keep running, so a release of pause mid-high-phase does not create a false tick.
- No arithmetic overflow other than the specified addr wrap. disp_* hold their last value outside SCAN_CAP.

Test Plan:
- Apply rst for 2 clk with slow_clk toggling -> every output 0, state IDLE, no mem_en pulse until start.
- AW=4, DW=8, SEED=A5, slow_clk period 4 clk; start=1, mode=1 -> 16 one-clk writes.
  - Addresses 0..15, wdata A5,A4,A7,A6,...,AA.
  - Then 16 reads, each followed 1 clk later by disp_valid with disp_data matching (addr 15 -> AA).
  - done=1 after last capture; busy=0.
- Memory model preloaded mem[i]=i*3; start, mode=0 -> no mem_we.
  - 16 reads; disp_data sequence 00,03,06,...,2D.
  - Consecutive disp_valid pulses 4 clk apart.
- During SCAN, assert pause for 3 tick periods after the read of addr 5 issues:
  - addr 5 still captured.
  - No mem_en while paused; mem_addr holds.
  - First read after release is addr 6.
- Assert rst one clk after the addr-7 write in FILL:
  - Next clk busy=0, mem_en=0, mem_addr=0, state IDLE.
  - New start with mode=1 writes addr 0 first (wdata A5).
- Pulse start mid-scan -> ignored, sequence continues unchanged.
  - Start in DONE -> done drops next clk and a fresh run begins at addr 0.
